// File: rtl/io_bus_responder_pkg.sv
// Shared constants for the simple I/O bus device family: device numbers,
// CONI/CONO bit positions (as vector indices of a 0:35 word), FSM encoding.
package io_bus_responder_pkg;

  localparam int WORD_W = 36;

  localparam logic [6:0] DEV_TTY = 7'o24;
  localparam logic [6:0] DEV_PTP = 7'o20;
  localparam logic [6:0] DEV_PTR = 7'o21;

  // Word bit n (0 = MSB) lives at vector index WORD_W-1-n.
  localparam int BIT_OVR      = WORD_W - 1 - 29;
  localparam int BIT_FLUSH    = WORD_W - 1 - 30;
  localparam int BIT_IN_FULL  = WORD_W - 1 - 30;
  localparam int BIT_OUT_FULL = WORD_W - 1 - 31;
  localparam int BIT_OUT_DONE = WORD_W - 1 - 32;
  localparam int BIT_PI_LO    = WORD_W - 1 - 35;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } io_state_e;

  function automatic logic [WORD_W-1:0] coni_word(input logic overrun,
                                                  input logic in_full,
                                                  input logic out_full,
                                                  input logic out_done,
                                                  input logic [2:0] pi_level);
    logic [WORD_W-1:0] w;
    w = '0;
    w[BIT_OVR]                   = overrun;
    w[BIT_IN_FULL]               = in_full;
    w[BIT_OUT_FULL]              = out_full;
    w[BIT_OUT_DONE]              = out_done;
    w[BIT_PI_LO+2:BIT_PI_LO]     = pi_level;
    return w;
  endfunction

  // One-hot PI request; level 0 means no channel assigned.
  function automatic logic [6:0] pi_onehot(input logic [2:0] level, input logic attn);
    logic [6:0] v;
    v = 7'd0;
    if (level != 3'd0) begin
      v = {6'd0, attn} << (level - 3'd1);
    end else begin
      v = 7'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/io_bus_responder_word_buffer.sv
// Single-entry valid/ready holding register; flush empties it and beats any load.
module io_word_buffer
  import io_bus_responder_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;

  // Holding register: load when empty, release on consumer handshake.
  always_ff @(posedge clk) begin
    if (clear) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (flush) begin
      full_r <= 1'b0;
    end else if (in_valid && !full_r) begin
      full_r <= 1'b1;
      data_r <= in_data;
    end else if (full_r && out_ready) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign in_ready  = !full_r;
  assign out_valid = full_r;
  assign out_data  = data_r;

endmodule

// File: rtl/io_bus_responder.sv
// One addressable I/O bus device: DATAI/DATAO/CONI/CONO responder with
// one-word output and input buffers bridging to a peripheral word stream.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter logic [6:0] DEVNUM = 7'o24,
  parameter int         WIDTH  = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_clear,
  input  logic             io_req,
  input  logic [6:0]       io_dev,
  input  logic             io_cond,
  input  logic             io_write,
  input  logic [WIDTH-1:0] io_wdata,
  output logic [WIDTH-1:0] io_rdata,
  output logic             io_ack,
  output logic [6:0]       pi_req,
  output logic [WIDTH-1:0] dev_out_data,
  output logic             dev_out_valid,
  input  logic             dev_out_ready,
  input  logic [WIDTH-1:0] dev_in_data,
  input  logic             dev_in_valid,
  output logic             dev_in_ready
);

  io_state_e        state_r, state_s;
  logic             rst_s;
  logic             hit_s, datao_s, datai_s, cono_s, coni_s, flush_s;
  logic             out_room_s, out_accept_s, drain_s;
  logic             in_full_s;
  logic [WIDTH-1:0] in_buf_s;
  logic             out_done_r, overrun_r, io_ack_r;
  logic [2:0]       pi_level_r;
  logic [WIDTH-1:0] io_rdata_r;
  logic [6:0]       pi_req_r;

  assign rst_s   = reset | io_clear;
  assign hit_s   = (state_r == ST_IDLE) && io_req && (io_dev == DEVNUM);
  assign datao_s = hit_s && !io_cond &&  io_write;
  assign datai_s = hit_s && !io_cond && !io_write;
  assign cono_s  = hit_s &&  io_cond &&  io_write;
  assign coni_s  = hit_s &&  io_cond && !io_write;
  assign flush_s = cono_s && io_wdata[BIT_FLUSH];

  assign out_accept_s = datao_s && out_room_s;
  assign drain_s      = dev_out_valid && dev_out_ready;

  io_word_buffer #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .clear     (rst_s),
    .flush     (flush_s),
    .in_valid  (datao_s),
    .in_data   (io_wdata),
    .in_ready  (out_room_s),
    .out_valid (dev_out_valid),
    .out_data  (dev_out_data),
    .out_ready (dev_out_ready)
  );

  io_word_buffer #(.WIDTH(WIDTH)) u_in_buf (
    .clk       (clk),
    .clear     (rst_s),
    .flush     (flush_s),
    .in_valid  (dev_in_valid),
    .in_data   (dev_in_data),
    .in_ready  (dev_in_ready),
    .out_valid (in_full_s),
    .out_data  (in_buf_s),
    .out_ready (datai_s)
  );

  // Bus handshake state register.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: a new request is only seen once back in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) state_s = ST_ACK;
        else       state_s = ST_IDLE;
      end
      ST_ACK:  state_s = ST_HOLD;
      ST_HOLD: begin
        if (!io_req) state_s = ST_IDLE;
        else         state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Device condition bits and bus response registers.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      out_done_r <= 1'b1;
      overrun_r  <= 1'b0;
      pi_level_r <= 3'd0;
      io_ack_r   <= 1'b0;
      io_rdata_r <= '0;
      pi_req_r   <= 7'd0;
    end else begin
      io_ack_r <= hit_s;
      pi_req_r <= pi_onehot(pi_level_r, in_full_s | out_done_r | overrun_r);

      if (flush_s || drain_s) out_done_r <= 1'b1;
      else if (out_accept_s)  out_done_r <= 1'b0;
      else                    out_done_r <= out_done_r;

      // DATAO into a full buffer loses the word; even if it drains this cycle.
      if (datao_s && !out_room_s)          overrun_r <= 1'b1;
      else if (cono_s && io_wdata[BIT_OVR]) overrun_r <= 1'b0;
      else                                  overrun_r <= overrun_r;

      if (cono_s) pi_level_r <= io_wdata[BIT_PI_LO+2:BIT_PI_LO];
      else        pi_level_r <= pi_level_r;

      if (datai_s)     io_rdata_r <= in_buf_s;
      else if (coni_s) io_rdata_r <= coni_word(overrun_r, in_full_s, dev_out_valid,
                                               out_done_r, pi_level_r);
      else             io_rdata_r <= io_rdata_r;
    end
  end

  assign io_ack   = io_ack_r;
  assign io_rdata = io_rdata_r;
  assign pi_req   = pi_req_r;

endmodule
